muldiv_arbiter: RTL and testbench

Sequencer and arbiter that shares one iterative multiply/divide engine between two requesters, such as the core and a second master. It accepts operations over per-requester valid/ready handshakes and grants them round-robin. It drives the engine's one-cycle init pulse, counts iterations, and captures the result. The result is held on the winner's response port until accepted.

---
 rtl/muldiv_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter
//
// Shares one iterative multiply/divide engine between two requesters.
// Requests are granted round-robin while idle. The block latches the
// operands, pulses the engine's init input for one cycle and counts N
// iterations. It then captures the engine result and holds it on the
// winning requester's response port until that requester accepts it.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   reqX_valid/ready        request handshake (X = 0, 1)
//   reqX_op                 0 = signed multiply, 1 = signed divide
//   reqX_a, reqX_b          operands
//   rspX_valid/ready        response handshake
//   rspX_data, rspX_err     result and divide-by-zero flag
//   eng_init                one-cycle engine load pulse
//   eng_op, eng_a, eng_b    engine operation select and operands
//   eng_result              engine combinational result
//   busy                    high whenever an operation is in flight
module muldiv_arbiter #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [N-1:0] rsp0_data,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp1_data,
    output logic         rsp1_err,
    output logic         eng_init,
    output logic         eng_op,
    output logic [N-1:0] eng_a,
    output logic [N-1:0] eng_b,
    input  logic [N-1:0] eng_result,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t        state;
    logic          last;
    logic          owner;
    logic          op_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [CW-1:0] count;

    logic          grant0;
    logic          grant1;
    logic          handshake;
    logic          sel_op;
    logic [N-1:0]  sel_a;
    logic [N-1:0]  sel_b;
    logic          div_zero;
    logic          rsp_taken;

    // On a tie, the requester that was not granted last wins. "last"
    // resets to req1 so that req0 wins the first tie after reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last;
                grant1 = ~last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign handshake  = grant0 | grant1;

    assign sel_op   = grant1 ? req1_op : req0_op;
    assign sel_a    = grant1 ? req1_a  : req0_a;
    assign sel_b    = grant1 ? req1_b  : req0_b;
    assign div_zero = sel_op && (sel_b == '0);

    assign rsp_taken = owner ? rsp1_ready : rsp0_ready;

    assign eng_op = op_q;
    assign eng_a  = a_q;
    assign eng_b  = b_q;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last       <= 1'b1;
            owner      <= 1'b0;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            count      <= '0;
            eng_init   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        owner <= grant1;
                        last  <= grant1;
                        count <= '0;
                        // Divide by zero never starts the engine; the
                        // all-ones result is posted on the next cycle.
                        if (div_zero) begin
                            state <= DONE;
                            if (grant1) begin
                                rsp1_valid <= 1'b1;
                                rsp1_data  <= '1;
                                rsp1_err   <= 1'b1;
                            end else begin
                                rsp0_valid <= 1'b1;
                                rsp0_data  <= '1;
                                rsp0_err   <= 1'b1;
                            end
                        end else begin
                            state    <= INIT;
                            eng_init <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    eng_init <= 1'b0;
                    count    <= count + 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    // The counter reads 1..N across the RUN cycles, so the
                    // engine has had N cycles when it reaches N.
                    if (count == CW'(N)) begin
                        state <= DONE;
                        if (owner) begin
                            rsp1_valid <= 1'b1;
                            rsp1_data  <= eng_result;
                            rsp1_err   <= 1'b0;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_data  <= eng_result;
                            rsp0_err   <= 1'b0;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_taken) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Testbench for muldiv_arbiter. It contains a behavioural engine model
// that produces the correct result only N cycles after init, a
// vector table, a response scoreboard and hand-written multi-cycle
// sequences.
module tb_muldiv_arbiter;

    localparam int N  = 32;
    localparam int CW = 6;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic [31:0] rsp0_data;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp1_data;
    logic        eng_init, eng_op;
    logic [31:0] eng_a, eng_b, eng_result;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int init_cnt = 0;
    int init_cyc = -1;

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   grant_q[$];

    muldiv_arbiter #(.N(N), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .eng_init(eng_init), .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
        .eng_result(eng_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        if (!op)
            r = 32'($signed(a) * $signed(b));
        else if (b == 32'd0)
            r = '1;
        else
            r = 32'($signed(a) / $signed(b));
        return r;
    endfunction

    // Engine model: loads on the init edge and shows garbage until it has
    // had N cycles, so an early capture returns the wrong value.
    int          eng_cnt = 63;
    logic        eng_lop = 1'b0;
    logic [31:0] eng_la = '0, eng_lb = '0;
    always @(posedge clk) begin
        if (eng_init) begin
            eng_cnt <= 0;
            eng_lop <= eng_op;
            eng_la  <= eng_a;
            eng_lb  <= eng_b;
        end else if (eng_cnt < 63) begin
            eng_cnt <= eng_cnt + 1;
        end
    end
    assign eng_result = (eng_cnt >= N - 1) ? model(eng_lop, eng_la, eng_lb) : 32'hA5C3_3C5A;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pushes expectations at request handshakes and pops them at
    // response handshakes; also watches mutual-exclusion rules.
    always @(negedge clk) begin
        exp_t e;
        if (eng_init) begin
            init_cnt = init_cnt + 1;
            init_cyc = cyc;
        end
        if (reset) begin
            checkOutput("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
            checkOutput("rsp_valid_exclusive", 32'(rsp0_valid & rsp1_valid), 32'd0);
            if (req0_valid && req0_ready) begin
                sb_q.push_back('{0, model(req0_op, req0_a, req0_b), req0_op && req0_b == 32'd0});
                grant_q.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                sb_q.push_back('{1, model(req1_op, req1_a, req1_b), req1_op && req1_b == 32'd0});
                grant_q.push_back(1);
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (rsp0_valid) begin
                        checkOutput("sb_owner", 32'd0, 32'(e.who));
                        checkOutput("sb_data", rsp0_data, e.data);
                        checkOutput("sb_err", 32'(rsp0_err), 32'(e.err));
                    end else begin
                        checkOutput("sb_owner", 32'd1, 32'(e.who));
                        checkOutput("sb_data", rsp1_data, e.data);
                        checkOutput("sb_err", 32'(rsp1_err), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic driveReq(input int who, input logic op, input logic [31:0] a,
                            input logic [31:0] b);
        if (who == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic waitHandshake(input int who, output int hs);
        int n = 0;
        hs = -1;
        forever begin
            @(negedge clk);
            if ((who == 0 && req0_valid && req0_ready) ||
                (who == 1 && req1_valid && req1_ready)) begin
                hs = cyc;
                break;
            end
            n++;
            if (n >= 200) begin
                checkOutput("handshake_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    // Drives a request, waits for its grant and withdraws it one edge later.
    task automatic applyStimulus(input int who, input logic op, input logic [31:0] a,
                                 input logic [31:0] b, output int hs);
        driveReq(who, op, a, b);
        waitHandshake(who, hs);
        @(posedge clk);
        #1;
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
    endtask

    task automatic waitResponse(input int who, output int rc, output logic [31:0] d,
                                output logic e, output logic other);
        int n = 0;
        rc = -1; d = '0; e = 1'b0; other = 1'b0;
        forever begin
            @(negedge clk);
            if (who == 0 ? rsp1_valid : rsp0_valid) other = 1'b1;
            if (who == 0 ? rsp0_valid : rsp1_valid) begin
                rc = cyc;
                d  = (who == 0) ? rsp0_data : rsp1_data;
                e  = (who == 0) ? rsp0_err  : rsp1_err;
                break;
            end
            n++;
            if (n >= 200) begin
                checkOutput("response_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    typedef struct {
        int          who;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int hs, rc, hs1, base, init0, n;
        logic [31:0] d;
        logic e, other;

        vecs[0] = '{0, 1'b0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0, 34};
        vecs[1] = '{1, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 34};
        vecs[2] = '{0, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1};
        vecs[3] = '{1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 34};
        vecs[4] = '{0, 1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 34};
        vecs[5] = '{1, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0000000F, 1'b0, 34};
        vecs[6] = '{1, 1'b1, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 1};
        vecs[7] = '{0, 1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 34};
        vecs[8] = '{0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34};

        reset = 1'b0;
        req0_valid = 1'b0; req0_op = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state, with both requests pending while reset is low.
        repeat (3) @(posedge clk);
        #1;
        driveReq(0, 1'b0, 32'd2, 32'd3);
        driveReq(1, 1'b1, 32'd9, 32'd2);
        @(negedge clk);
        checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        checkOutput("rst_rsp0_data", rsp0_data, 32'd0);
        checkOutput("rst_rsp1_data", rsp1_data, 32'd0);
        checkOutput("rst_rsp0_err", 32'(rsp0_err), 32'd0);
        checkOutput("rst_rsp1_err", 32'(rsp1_err), 32'd0);
        checkOutput("rst_eng_init", 32'(eng_init), 32'd0);
        checkOutput("rst_eng_a", eng_a, 32'd0);
        checkOutput("rst_eng_b", eng_b, 32'd0);

        // Round-robin: both requesters stay valid; req0 wins the first tie.
        @(posedge clk);
        #1 reset = 1'b1;
        base = grant_q.size();
        n = 0;
        while (grant_q.size() < base + 4 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("rr_grant_count", 32'(grant_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < grant_q.size())
                checkOutput($sformatf("rr_grant%0d", i), 32'(grant_q[base + i]), 32'(i % 2));
        end
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("rr_drain", 32'(sb_q.size()), 32'd0);

        // Table-driven single operations with rsp ready tied high.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            init0 = init_cnt;
            applyStimulus(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, hs);
            waitResponse(vecs[i].who, rc, d, e, other);
            checkOutput($sformatf("vec%0d_latency", i), 32'(rc - hs), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d_data", i), d, vecs[i].data);
            checkOutput($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
            checkOutput($sformatf("vec%0d_other_rsp", i), 32'(other), 32'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_init_pulses", i), 32'(init_cnt - init0),
                        vecs[i].err ? 32'd0 : 32'd1);
            if (!vecs[i].err)
                checkOutput($sformatf("vec%0d_init_cycle", i), 32'(init_cyc), 32'(hs + 1));
        end

        // Response backpressure with a competing request from req1.
        rsp0_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'd7, 32'hFFFFFFFA, hs);
        driveReq(1, 1'b0, 32'd3, 32'd4);
        waitResponse(0, rc, d, e, other);
        checkOutput("bp_latency", 32'(rc - hs), 32'd34);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_held", 32'(rsp0_valid), 32'd1);
            checkOutput("bp_data_held", rsp0_data, 32'hFFFFFFD6);
            checkOutput("bp_req1_blocked", 32'(req1_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp0_ready = 1'b1;
        base = cyc;
        waitHandshake(1, hs1);
        checkOutput("bp_req1_grant_cycle", 32'(hs1), 32'(base + 1));
        @(posedge clk);
        #1 req1_valid = 1'b0;
        waitResponse(1, rc, d, e, other);
        checkOutput("bp_req1_latency", 32'(rc - hs1), 32'd34);
        checkOutput("bp_req1_data", d, 32'd12);

        // Reset in the middle of a multiply, then a fresh req1 operation.
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 32'd7, 32'hFFFFFFFA, hs);
        while (cyc < hs + 10) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        checkOutput("midrst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        checkOutput("midrst_eng_init", 32'(eng_init), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 32'd123, 32'hFFFFFFD3, hs);
        waitResponse(1, rc, d, e, other);
        checkOutput("midrst_latency", 32'(rc - hs), 32'd34);
        checkOutput("midrst_data", d, 32'hFFFFEA61);
        checkOutput("midrst_err", 32'(e), 32'd0);
        checkOutput("midrst_no_rsp0", 32'(other), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] global timeout");
    end

endmodule
